// File: rtl/sr_drv_pkg.sv
// Shared definitions for the SR flip-flop pulse driver.
//   state_t      - FSM state encoding
//   PULSE_W_DEF  - default number of drive cycles per command
//   TIMEOUT_DEF  - default number of confirmation-wait cycles
//   CNT_W        - width of the shared pulse/wait counter
//   cnt_sat_inc  - saturating counter increment
package sr_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int PULSE_W_DEF = 2;
  localparam int TIMEOUT_DEF = 8;
  localparam int CNT_W       = 8;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/sr_pulse_driver.sv
// Drives an external SR flip-flop to a requested level and confirms it via
// the Q feedback.
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   command offered
//   req_val    in   requested Q level
//   req_ready  out  driver idle and able to accept a command
//   S, R       out  set / reset drive (never both high)
//   enable     out  enable drive, high only while pulsing
//   q_fb       in   Q from the driven flop, synchronous to clk
//   done       out  one-cycle completion strobe
//   err        out  confirmation timed out (valid with done only)
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | ready for a command
// ST_PULSE | driving S/R with enable for PULSE_W cycles
// ST_WAIT  | watching q_fb for the target level, up to TIMEOUT cycles
// ST_RESP  | one-cycle done strobe, err reports a timeout
module sr_pulse_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_W = PULSE_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_val,
  output logic req_ready,
  output logic S,
  output logic R,
  output logic enable,
  input  logic q_fb,
  output logic done,
  output logic err
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             target, target_nxt;
  logic             s_nxt, r_nxt, en_nxt, done_nxt, err_nxt, ready_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      target    <= 1'b0;
      S         <= 1'b0;
      R         <= 1'b0;
      enable    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      target    <= target_nxt;
      S         <= s_nxt;
      R         <= r_nxt;
      enable    <= en_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      req_ready <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    target_nxt = target;
    err_nxt    = 1'b0;

    case (state)
      ST_IDLE: begin
        // req_ready stays low in IDLE for the first cycle after reset, so
        // the handshake must use the registered ready, not the state alone.
        if (req_valid && req_ready) begin
          target_nxt = req_val;
          cnt_nxt    = CNT_ONE;
          state_nxt  = (req_val == q_fb) ? ST_RESP : ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (cnt >= PULSE_LAST) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = cnt_sat_inc(cnt);
        end
      end
      ST_WAIT: begin
        // A match wins over the timeout on the final wait cycle.
        if (q_fb == target) begin
          state_nxt = ST_RESP;
        end else if (cnt >= WAIT_LAST) begin
          state_nxt = ST_RESP;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_sat_inc(cnt);
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    en_nxt    = (state_nxt == ST_PULSE);
    s_nxt     = en_nxt && target_nxt;
    r_nxt     = en_nxt && !target_nxt;
    done_nxt  = (state_nxt == ST_RESP);
    ready_nxt = (state_nxt == ST_IDLE);
  end

endmodule

// File: tb/tb_sr_pulse_driver.sv
module tb_sr_pulse_driver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0;
  logic req_val = 1'b0;
  logic req_ready, S, R, enable, done, err;
  logic q_fb;

  // Flop model and overrides
  logic q_model = 1'b0;
  logic load = 1'b0;
  logic load_val = 1'b0;
  logic stuck_en = 1'b0;
  logic stuck_val = 1'b0;
  logic sr_overlap = 1'b0;

  int total = 0;
  int bad = 0;

  wire [5:0] outs = {req_ready, S, R, enable, done, err};

  sr_pulse_driver #(.PULSE_W(2), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_val(req_val),
    .req_ready(req_ready), .S(S), .R(R), .enable(enable),
    .q_fb(q_fb), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) q_model <= load_val;
    else if (enable) begin
      if (S) q_model <= 1'b1;
      else if (R) q_model <= 1'b0;
    end
  end

  assign q_fb = stuck_en ? stuck_val : q_model;

  always @(negedge clk) if (S && R) sr_overlap <= 1'b1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_model(input logic v);
    stuck_en = 1'b0;
    load = 1'b1;
    load_val = v;
    step();
    load = 1'b0;
  endtask

  // outs = {req_ready, S, R, enable, done, err}
  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    total++;
    if (outs !== 6'b000000) begin
      bad++; $display("FAIL reset_async outs=%b want=000000", outs);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (outs !== 6'b000000) begin
        bad++; $display("FAIL reset_held outs=%b want=000000", outs);
      end
    end
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b0) begin
      bad++; $display("FAIL ready_before_edge got=%b want=0", req_ready);
    end
    step();
    total++;
    if (outs !== 6'b100000) begin
      bad++; $display("FAIL ready_after_edge outs=%b want=100000", outs);
    end
  endtask

  task automatic test_change();
    set_model(1'b0);
    req_valid = 1'b1; req_val = 1'b1;
    step();
    req_valid = 1'b0;
    total++;
    if (outs !== 6'b010100) begin
      bad++; $display("FAIL change_c1 outs=%b want=010100", outs);
    end
    step();
    total++;
    if (outs !== 6'b010100) begin
      bad++; $display("FAIL change_c2 outs=%b want=010100", outs);
    end
    step();
    total++;
    if (outs !== 6'b000000) begin
      bad++; $display("FAIL change_c3 outs=%b want=000000", outs);
    end
    step();
    total++;
    if (outs !== 6'b000010) begin
      bad++; $display("FAIL change_done outs=%b want=000010", outs);
    end
    step();
    total++;
    if (outs !== 6'b100000 || q_model !== 1'b1) begin
      bad++; $display("FAIL change_idle outs=%b q=%b want=100000 q=1", outs, q_model);
    end
  endtask

  task automatic test_matched();
    stuck_en = 1'b1; stuck_val = 1'b1;
    req_valid = 1'b1; req_val = 1'b1;
    step();
    req_valid = 1'b0;
    total++;
    if (outs !== 6'b000010) begin
      bad++; $display("FAIL matched_c1 outs=%b want=000010", outs);
    end
    step();
    total++;
    if (outs !== 6'b100000) begin
      bad++; $display("FAIL matched_c2 outs=%b want=100000", outs);
    end
  endtask

  task automatic test_timeout();
    stuck_en = 1'b1; stuck_val = 1'b0;
    req_valid = 1'b1; req_val = 1'b1;
    step();
    // Busy-time commands with the opposite level must be ignored.
    req_val = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      total++;
      if (outs !== 6'b010100) begin
        bad++; $display("FAIL timeout_pulse c%0d outs=%b want=010100", c, outs);
      end
      step();
    end
    for (int c = 3; c <= 6; c++) begin
      if (c == 6) req_valid = 1'b0;
      total++;
      if (outs !== 6'b000000) begin
        bad++; $display("FAIL timeout_wait c%0d outs=%b want=000000", c, outs);
      end
      step();
    end
    total++;
    if (outs !== 6'b000011) begin
      bad++; $display("FAIL timeout_c7 outs=%b want=000011", outs);
    end
    step();
    total++;
    if (outs !== 6'b100000) begin
      bad++; $display("FAIL timeout_c8 outs=%b want=100000", outs);
    end
    step();
    total++;
    if (outs !== 6'b100000) begin
      bad++; $display("FAIL timeout_no_queue outs=%b want=100000", outs);
    end
  endtask

  task automatic test_last_cycle_match();
    stuck_en = 1'b1; stuck_val = 1'b0;
    req_valid = 1'b1; req_val = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 1; c < 6; c++) step();
    stuck_val = 1'b1;
    step();
    total++;
    if (outs !== 6'b000010) begin
      bad++; $display("FAIL last_wait_match outs=%b want=000010", outs);
    end
    step();
  endtask

  task automatic test_reset_path();
    stuck_en = 1'b1; stuck_val = 1'b1;
    req_valid = 1'b1; req_val = 1'b0;
    step();
    req_valid = 1'b0;
    total++;
    if (outs !== 6'b001100) begin
      bad++; $display("FAIL rdrive_c1 outs=%b want=001100", outs);
    end
    step();
    stuck_val = 1'b0;
    step();
    step();
    total++;
    if (outs !== 6'b000010) begin
      bad++; $display("FAIL rdrive_done outs=%b want=000010", outs);
    end
    step();
  endtask

  task automatic test_reset_mid_pulse();
    bit got_done;
    set_model(1'b0);
    req_valid = 1'b1; req_val = 1'b1;
    step();
    req_valid = 1'b0;
    total++;
    if (outs !== 6'b010100) begin
      bad++; $display("FAIL abort_pulse outs=%b want=010100", outs);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (outs !== 6'b000000) begin
      bad++; $display("FAIL abort_async outs=%b want=000000", outs);
    end
    step();
    rst = 1'b0;
    step();
    total++;
    if (outs !== 6'b100000 || q_model !== 1'b0) begin
      bad++; $display("FAIL abort_recover outs=%b q=%b want=100000 q=0", outs, q_model);
    end
    req_valid = 1'b1; req_val = 1'b1;
    step();
    req_valid = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      if (done) got_done = 1'b1;
      else step();
    end
    total++;
    if (!got_done || err !== 1'b0 || q_model !== 1'b1) begin
      bad++; $display("FAIL abort_next_cmd done_seen=%b err=%b q=%b want=1 0 1", got_done, err, q_model);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    int dones = 0;
    int err_stray = 0;
    set_model(1'b0);
    req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      req_val = ~req_val;
      if (req_valid && req_ready) accepts++;
      step();
      if (done) dones++;
      if (err && !done) err_stray++;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) dones++;
    end
    total++;
    if (accepts !== dones || accepts < 4) begin
      bad++; $display("FAIL b2b_count accepts=%0d dones=%0d want equal and >=4", accepts, dones);
    end
    total++;
    if (err_stray !== 0) begin
      bad++; $display("FAIL b2b_err_without_done got=%0d want=0", err_stray);
    end
    total++;
    if (sr_overlap !== 1'b0) begin
      bad++; $display("FAIL s_and_r_overlap got=%b want=0", sr_overlap);
    end
  endtask

  initial begin
    test_reset();
    test_change();
    test_matched();
    test_timeout();
    test_last_cycle_match();
    test_reset_path();
    test_reset_mid_pulse();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
